// File: rtl/ntt_stage_counter.sv
// Butterfly address sequencer for a multi-stage NTT: counts 0..last per pass over a configurable
// number of passes, with wrap/done pulses, stall, abort, one-shot and continuous modes.
module ntt_stage_counter #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic              in_stall,
  input  logic [WIDTH-1:0]  cfg_last,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              cfg_mode,
  output logic [WIDTH-1:0]  counter_out,
  output logic [PASS_W-1:0] pass_out,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d, last_q, last_d;
  logic [PASS_W-1:0]  pass_q, pass_d, passes_q, passes_d;
  logic               mode_q, mode_d;
  logic               wrap_q, wrap_d, done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pass_q   <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= '0;
      passes_q <= PASS_W'(1);
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      last_q   <= last_d;
      passes_q <= passes_d;
      mode_q   <= mode_d;
    end
  end

  // wrap/done are pulses: they default low and are only raised on the counting path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    last_d   = last_q;
    passes_d = passes_q;
    mode_d   = mode_q;
    if (in_start) begin
      state_d  = RUN;
      cnt_d    = '0;
      pass_d   = '0;
      last_d   = cfg_last;
      passes_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
      mode_d   = cfg_mode;
    end else if (in_stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pass_d  = '0;
    end else if (state_q == RUN && !in_stall) begin
      if (cnt_q != last_q) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        if (pass_q != passes_q - PASS_W'(1)) begin
          pass_d = pass_q + PASS_W'(1);
        end else begin
          pass_d = '0;
          done_d = 1'b1;
          if (!mode_q) state_d = IDLE;
        end
      end
    end
  end

  always_comb begin
    counter_out = cnt_q;
    pass_out    = pass_q;
    busy        = (state_q == RUN);
    wrap        = wrap_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_ntt_stage_counter.sv
// Bench for ntt_stage_counter: reset-state table, directed corner sequences and a randomized
// run checked against an elapsed-count arithmetic model.
module tb_ntt_stage_counter;
  localparam int WIDTH = 8, PASS_W = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic in_start = 1'b0, in_stop = 1'b0, in_stall = 1'b0, cfg_mode = 1'b0;
  logic [WIDTH-1:0]  cfg_last = '0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic [WIDTH-1:0]  counter_out;
  logic [PASS_W-1:0] pass_out;
  logic busy, wrap, done;

  ntt_stage_counter #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_stop(in_stop), .in_stall(in_stall),
    .cfg_last(cfg_last), .cfg_passes(cfg_passes), .cfg_mode(cfg_mode),
    .counter_out(counter_out), .pass_out(pass_out), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Model: t = non-stalled cycles elapsed since the first 0 of the current run.
  bit m_run, m_wrap, m_done, m_mode;
  int t, m_len, m_passes;

  typedef struct {
    logic start, stop, stall;
    logic [WIDTH-1:0] last;
    logic [PASS_W-1:0] passes;
    logic mode;
    int cnt, pas;
    logic bsy, wrp, dne;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wrap = 0; m_done = 0; m_mode = 0; t = 0; m_len = 1; m_passes = 1;
  endtask

  task automatic model_step();
    m_wrap = 0; m_done = 0;
    if (in_start) begin
      m_run = 1; t = 0;
      m_len = int'(cfg_last) + 1;
      m_passes = (cfg_passes == 0) ? 1 : int'(cfg_passes);
      m_mode = cfg_mode;
    end else if (in_stop) begin
      m_run = 0; t = 0;
    end else if (m_run && !in_stall) begin
      t++;
      if (t % m_len == 0) m_wrap = 1;
      if (t == m_passes * m_len) begin
        m_done = 1; t = 0;
        if (!m_mode) m_run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    chk("counter_out", int'(counter_out), m_run ? t % m_len : 0);
    chk("pass_out", int'(pass_out), m_run ? t / m_len : 0);
    chk("busy", int'(busy), int'(m_run));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic start_run(input int l, input int p, input bit m);
    cfg_last = WIDTH'(l); cfg_passes = PASS_W'(p); cfg_mode = m;
    in_start = 1; tick(); in_start = 0;
    check_model();
  endtask

  initial begin
    int n, nw, nd;
    model_reset();
    #12;
    chk("reset_counter", int'(counter_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({wrap, done}), 0);
    rst = 1;
    #4;

    // start,stop,stall,last,passes,mode | cnt,pass,busy,wrap,done
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 0, 1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd2, 4'd2, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 2, 1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd2, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'd2, 4'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd2, 4'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd5, 4'd3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd5, 4'd3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      in_start = tbl[i].start; in_stop = tbl[i].stop; in_stall = tbl[i].stall;
      cfg_last = tbl[i].last; cfg_passes = tbl[i].passes; cfg_mode = tbl[i].mode;
      tick();
      chk($sformatf("tbl%0d_cnt", i), int'(counter_out), tbl[i].cnt);
      chk($sformatf("tbl%0d_pass", i), int'(pass_out), tbl[i].pas);
      chk($sformatf("tbl%0d_flags", i), int'({busy, wrap, done}),
          int'({tbl[i].bsy, tbl[i].wrp, tbl[i].dne}));
    end
    in_start = 0; in_stop = 0; in_stall = 0;

    // Full 256-count one-shot pass
    start_run(255, 1, 0);
    n = 0;
    while (!done && n < 400) begin tick(); check_model(); n++; end
    chk("oneshot256_len", n, 256);
    chk("oneshot256_idle", int'(busy), 0);
    tick(); check_model();

    // Three passes of 8, one-shot
    start_run(7, 3, 0);
    n = 0; nw = 0;
    while (!done && n < 100) begin tick(); check_model(); n++; if (wrap) nw++; end
    chk("p3_len", n, 24);
    chk("p3_wraps", nw, 3);

    // Continuous mode then abort
    start_run(7, 3, 1);
    nd = 0;
    for (int i = 0; i < 48; i++) begin tick(); check_model(); if (done) nd++; end
    chk("cont_dones", nd, 2);
    chk("cont_busy", int'(busy), 1);
    in_stop = 1; tick(); in_stop = 0; check_model();
    chk("stop_idle", int'({busy, done}), 0);

    // Stall for 5 cycles at counter 9
    start_run(15, 1, 0);
    n = 0;
    while (counter_out != 9 && n < 40) begin tick(); check_model(); n++; end
    chk("stall_reach9", int'(counter_out), 9);
    in_stall = 1;
    for (int i = 0; i < 5; i++) begin tick(); check_model(); n++; end
    chk("stall_hold9", int'(counter_out), 9);
    in_stall = 0;
    while (!done && n < 60) begin tick(); check_model(); n++; end
    chk("stall_len", n, 21);

    // Restart mid-run at 100 with start+stop together; cfg change mid-run ignored
    start_run(255, 1, 0);
    n = 0;
    while (counter_out != 100 && n < 200) begin tick(); n++; end
    in_stop = 1; cfg_last = 31;
    in_start = 1; tick(); in_start = 0; in_stop = 0; check_model();
    chk("restart_cnt", int'(counter_out), 0);
    cfg_last = 3;
    n = 0;
    while (!done && n < 80) begin tick(); check_model(); n++; end
    chk("restart_len", n, 32);

    // cfg_passes=0, cfg_last=0: single-cycle run
    start_run(0, 0, 0);
    tick(); check_model();
    chk("single_flags", int'({busy, wrap, done}), 3);

    // Asynchronous reset mid-run, between edges
    start_run(50, 2, 0);
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 0;
    #1;
    chk("async_cnt", int'(counter_out), 0);
    chk("async_flags", int'({busy, wrap, done}), 0);
    model_reset();
    tick(); check_model();
    #2 rst = 1;
    tick(); check_model();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_start = ($urandom_range(0, 39) == 0);
      in_stop  = ($urandom_range(0, 99) == 0);
      in_stall = ($urandom_range(0, 4) == 0);
      cfg_last = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
      cfg_passes = PASS_W'($urandom_range(0, 4));
      cfg_mode = 1'($urandom_range(0, 1));
      tick(); check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
